seq_10110_detector: RTL and testbench

- Serial bit-stream pattern detector for the sequence 1,0,1,1,0, with the first bit received first and overlapping matches allowed.
- Contains two independent FSMs fed by the same input: a Moore detector (registered, one-cycle-late flag) and a Mealy detector (combinational, same-cycle flag).
- Sits on a 1-bit serial data path; consumers pick whichever flag timing suits them.

---
 rtl/seq_10110_pkg.sv | 32 +++
 rtl/seq_10110_if.sv | 20 ++
 rtl/seq_10110_fsm.sv | 70 +++++++
 rtl/seq_10110_detector.sv | 28 ++
 tb/tb_seq_10110_detector.sv | 130 +++++++++++++
 5 files changed

// File: rtl/seq_10110_pkg.sv
// Shared definitions for the 10110 serial pattern detector: state encodings
// for both FSM flavours, the style selector and the pattern constant.
package seq_10110_pkg;

   localparam int STATE_W     = 3;
   localparam int PATTERN_LEN = 5;
   localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b10110;

   // Moore states are named after the longest matched prefix of the pattern
   typedef enum logic [STATE_W-1:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } moore_state_e;

   typedef enum logic [STATE_W-1:0] {
      M0 = 3'd0,
      M1 = 3'd1,
      M2 = 3'd2,
      M3 = 3'd3,
      M4 = 3'd4
   } mealy_state_e;

   typedef enum logic {
      STYLE_MOORE = 1'b0,
      STYLE_MEALY = 1'b1
   } fsm_style_e;

endpackage

// File: rtl/seq_10110_if.sv
// Serial data path bundle: one data bit in, two detect flags out.
interface seq_10110_if;

   logic j;
   logic w_moore;
   logic w_mealy;

   modport master (
      output j,
      input  w_moore,
      input  w_mealy
   );

   modport slave (
      input  j,
      output w_moore,
      output w_mealy
   );

endinterface

// File: rtl/seq_10110_fsm.sv
// One 10110 detector FSM; STYLE picks a registered Moore flag or a
// combinational same-cycle Mealy flag.
module seq_10110_fsm
   import seq_10110_pkg::*;
#(
   parameter fsm_style_e STYLE = STYLE_MOORE
) (
   input  logic clk,
   input  logic rst,
   input  logic j_i,
   output logic detect_o
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   generate
      if (STYLE == STYLE_MOORE) begin : g_moore
         // S5 keeps the trailing "10" so overlapping matches are seen
         always_comb begin
            state_d  = S0;
            detect_o = 1'b0;
            case (state_q)
               S0: state_d = j_i ? S1 : S0;
               S1: state_d = j_i ? S1 : S2;
               S2: state_d = j_i ? S3 : S0;
               S3: state_d = j_i ? S4 : S2;
               S4: state_d = j_i ? S1 : S5;
               S5: begin
                  state_d  = j_i ? S3 : S0;
                  detect_o = 1'b1;
               end
               default: begin
                  state_d  = S0;
                  detect_o = 1'b0;
               end
            endcase
         end
      end else begin : g_mealy
         // The flag follows j directly, so only its value at the edge counts
         always_comb begin
            state_d  = M0;
            detect_o = 1'b0;
            case (state_q)
               M0: state_d = j_i ? M1 : M0;
               M1: state_d = j_i ? M1 : M2;
               M2: state_d = j_i ? M3 : M0;
               M3: state_d = j_i ? M4 : M2;
               M4: begin
                  state_d  = j_i ? M1 : M2;
                  detect_o = ~j_i;
               end
               default: begin
                  state_d  = M0;
                  detect_o = 1'b0;
               end
            endcase
         end
      end
   endgenerate

endmodule

// File: rtl/seq_10110_detector.sv
// Top level: the same serial stream feeds a Moore and a Mealy detector.
module seq_10110_detector
   import seq_10110_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   seq_10110_if.slave bus
);

   seq_10110_fsm #(
      .STYLE (STYLE_MOORE)
   ) u_moore (
      .clk      (clk),
      .rst      (rst),
      .j_i      (bus.j),
      .detect_o (bus.w_moore)
   );

   seq_10110_fsm #(
      .STYLE (STYLE_MEALY)
   ) u_mealy (
      .clk      (clk),
      .rst      (rst),
      .j_i      (bus.j),
      .detect_o (bus.w_mealy)
   );

endmodule

// File: tb/tb_seq_10110_detector.sv
// Scoreboard bench for seq_10110_detector: stimulus queues per-cycle expected
// flags, a monitor samples just before each rising edge and compares.
module tb_seq_10110_detector;

   logic clk;
   logic rst;

   seq_10110_if bus ();

   seq_10110_detector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {
      string tag;
      logic  mealy;
      logic  moore;
   } expect_t;

   expect_t expQ[$];
   int      total = 0;
   int      bad   = 0;

   task automatic checkOutput(input string name, input logic actual, input logic required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, actual, required, $time);
      end
   endtask

   // Drive one bit just after the falling edge; its flags are sampled before the next rising edge
   task automatic applyStimulus(input string tag, input logic jBit, input logic expMealy, input logic expMoore);
      expect_t e;
      @(negedge clk);
      #1;
      bus.j   = jBit;
      e.tag   = tag;
      e.mealy = expMealy;
      e.moore = expMoore;
      expQ.push_back(e);
   endtask

   task automatic runVector(input string name, input string bits, input string mealyExp, input string mooreExp);
      for (int i = 0; i < bits.len(); i++) begin
         applyStimulus($sformatf("%s[%0d]", name, i), bits[i] == "1", mealyExp[i] == "1", mooreExp[i] == "1");
      end
   endtask

   initial begin : monitor
      expect_t e;
      forever begin
         @(negedge clk);
         #40;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".mealy"}, bus.w_mealy, e.mealy);
            checkOutput({e.tag, ".moore"}, bus.w_moore, e.moore);
         end
      end
   end

   initial begin : stimulus
      rst   = 1'b1;
      bus.j = 1'b0;

      repeat (2) begin
         @(negedge clk);
         #1;
         bus.j = ~bus.j;
         #20;
         checkOutput("resetHeld.mealy", bus.w_mealy, 1'b0);
         checkOutput("resetHeld.moore", bus.w_moore, 1'b0);
      end
      @(negedge clk);
      #1;
      bus.j = 1'b0;
      rst   = 1'b0;

      runVector("idleZeros", "000", "000", "000");
      runVector("single", "1011000", "0000100", "0000010");
      runVector("overlap", "1011011000", "0000100100", "0000010010");
      runVector("nearMiss", "10111011000", "00000000100", "00000000010");

      // Glitch in M4: j dips to 0 for 20 ns but is back to 1 at the edge
      runVector("glitchPre", "1011", "0000", "0000");
      @(negedge clk);
      #1;
      bus.j = 1'b1;
      #10;
      checkOutput("glitchBefore.mealy", bus.w_mealy, 1'b0);
      bus.j = 1'b0;
      #1;
      checkOutput("glitchLow.mealy", bus.w_mealy, 1'b1);
      checkOutput("glitchLow.moore", bus.w_moore, 1'b0);
      #19;
      bus.j = 1'b1;
      #1;
      checkOutput("glitchAfter.mealy", bus.w_mealy, 1'b0);
      runVector("glitchPost", "011000", "000100", "000010");

      // Asynchronous reset while the Moore flag is up
      runVector("rstPre", "10110", "00001", "00000");
      @(negedge clk);
      #1;
      bus.j = 1'b0;
      #10;
      checkOutput("rstBefore.moore", bus.w_moore, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("rstAsync.moore", bus.w_moore, 1'b0);
      checkOutput("rstAsync.mealy", bus.w_mealy, 1'b0);
      #5;
      rst = 1'b0;
      runVector("rstPost", "01100", "00000", "00000");

      @(negedge clk);
      #45;
      checkOutput("queueDrained", expQ.size() == 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
